// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback
// over a shared ALU and unified memory port; counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;

    assign state   = r_state;
    assign retired = r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_retired <= '0;
        end else begin
            if (instr_done)
                r_retired <= r_retired + CNT_W'(1);
            unique case (r_state)
                S_RST:    r_state <= S_FETCH;
                S_FETCH:  r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    unique case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  r_state <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ADDIWB: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                // Unused encodings fall back into the fetch loop
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                unique case (opcode)
                    OP_LW, OP_SW, OP_RTYPE,
                    OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:               illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for the multi-cycle MIPS control FSM.
module tb_mips_multicycle_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSource;
    logic [3:0]    state;
    logic          instr_done, illegal_op;
    logic [CW-1:0] retired;

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [17:0] w_out;
    assign w_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, instr_done, illegal_op};

    typedef struct {
        logic [5:0]    op;
        logic          mr;
        logic [3:0]    st;
        logic [17:0]   outs;
        logic [CW-1:0] ret;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic logic [17:0] mk(
        input logic pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, sa,
        input logic [1:0] sb, aop, pcs,
        input logic done, ill);
        return {pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, sa,
                sb, aop, pcs, done, ill};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [17:0] O_RST, O_FW, O_FR, O_DEC, O_ILL, O_MADR, O_MRD, O_MWB;
    logic [17:0] O_MWRW, O_MWRR, O_EXEC, O_AWB, O_BR, O_AEX, O_AWB2, O_JMP;

    vec_t vt[$];

    task automatic add(input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [17:0] o,
                       input int r);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.outs = o; v.ret = CW'(r);
        vt.push_back(v);
    endtask

    initial begin
        O_RST  = '0;
        O_FW   = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        O_FR   = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        O_DEC  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
        O_ILL  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
        O_MADR = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        O_MRD  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        O_MWB  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
        O_MWRW = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        O_MWRR = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
        O_EXEC = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
        O_AWB  = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
        O_BR   = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
        O_AEX  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        O_AWB2 = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
        O_JMP  = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);

        // R-type
        add(6'h00, 1, 0,  O_RST,  0);
        add(6'h00, 1, 1,  O_FR,   0);
        add(6'h00, 1, 2,  O_DEC,  0);
        add(6'h00, 1, 7,  O_EXEC, 0);
        add(6'h00, 1, 8,  O_AWB,  0);
        // lw with two wait cycles in MEMRD
        add(6'h23, 1, 1,  O_FR,   1);
        add(6'h23, 1, 2,  O_DEC,  1);
        add(6'h23, 1, 3,  O_MADR, 1);
        add(6'h23, 0, 4,  O_MRD,  1);
        add(6'h23, 0, 4,  O_MRD,  1);
        add(6'h23, 1, 4,  O_MRD,  1);
        add(6'h23, 1, 5,  O_MWB,  1);
        // sw, no wait
        add(6'h2b, 1, 1,  O_FR,   2);
        add(6'h2b, 1, 2,  O_DEC,  2);
        add(6'h2b, 1, 3,  O_MADR, 2);
        add(6'h2b, 1, 6,  O_MWRR, 2);
        // beq then j
        add(6'h04, 1, 1,  O_FR,   3);
        add(6'h04, 1, 2,  O_DEC,  3);
        add(6'h04, 1, 9,  O_BR,   3);
        add(6'h02, 1, 1,  O_FR,   4);
        add(6'h02, 1, 2,  O_DEC,  4);
        add(6'h02, 1, 12, O_JMP,  4);
        // illegal
        add(6'h3f, 1, 1,  O_FR,   5);
        add(6'h3f, 1, 2,  O_ILL,  5);
        // addi with a FETCH wait
        add(6'h08, 0, 1,  O_FW,   5);
        add(6'h08, 1, 1,  O_FR,   5);
        add(6'h08, 1, 2,  O_DEC,  5);
        add(6'h08, 1, 10, O_AEX,  5);
        add(6'h08, 1, 11, O_AWB2, 5);
        // sw with a wait in MEMWR
        add(6'h2b, 1, 1,  O_FR,   6);
        add(6'h2b, 1, 2,  O_DEC,  6);
        add(6'h2b, 1, 3,  O_MADR, 6);
        add(6'h2b, 0, 6,  O_MWRW, 6);
        add(6'h2b, 1, 6,  O_MWRR, 6);
        // lw, counter wraps 7 -> 0 on its retire
        add(6'h23, 1, 1,  O_FR,   7);
        add(6'h23, 1, 2,  O_DEC,  7);
        add(6'h23, 1, 3,  O_MADR, 7);
        add(6'h23, 1, 4,  O_MRD,  7);
        add(6'h23, 1, 5,  O_MWB,  7);
        add(6'h02, 1, 1,  O_FR,   0);
        add(6'h02, 1, 2,  O_DEC,  0);
        add(6'h02, 1, 12, O_JMP,  0);
        // lw parked in a MEMRD wait for the reset test
        add(6'h23, 1, 1,  O_FR,   1);
        add(6'h23, 1, 2,  O_DEC,  1);
        add(6'h23, 1, 3,  O_MADR, 1);
        add(6'h23, 0, 4,  O_MRD,  1);

        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'(w_out), 0);
        chk("reset_retired", int'(retired), 0);

        foreach (vt[i]) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            opcode = vt[i].op;
            mem_ready = vt[i].mr;
            #1;
            chk($sformatf("row%0d_state", i), int'(state), int'(vt[i].st));
            chk($sformatf("row%0d_outs", i), int'(w_out), int'(vt[i].outs));
            chk($sformatf("row%0d_retired", i), int'(retired), int'(vt[i].ret));
        end

        // Asynchronous reset during the MEMRD wait, before the next edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_outs", int'(w_out), 0);
        chk("async_rst_retired", int'(retired), 0);

        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'h00;
        @(negedge clk);
        #1;
        chk("recover_state", int'(state), 1);
        chk("recover_outs", int'(w_out), int'(O_FR));
        chk("recover_retired", int'(retired), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM for the MIPS datapath. It sequences one instruction over several cycles (fetch, decode, execute, memory, writeback) through a single shared ALU and a single unified memory port. It decodes the same opcode set as the single-cycle control unit: R-type, lw, sw, beq, addi and j. It stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous reset, active low.
opcode  in  6  instr[31:26] from the IR; stable from DECODE until the next IRWrite.
mem_ready  in  1  memory completes the current access this cycle.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load if ALU zero (beq).
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  instruction register load.
MemToReg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
RegDst  out  1  destination register: 1 = rd, 0 = rt.
RegWrite  out  1  register file write.
ALUSrcA  out  1  ALU A: 0 = PC, 1 = rs.
ALUSrcB  out  2  ALU B: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode.
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
state  out  4  current state encoding (debug).
instr_done  out  1  one-cycle pulse on the last cycle of each legal instruction.
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.
retired  out  CNT_W  count of legal instructions completed.

Behaviour:
- State register is 4 bits and is the only sequential state besides `retired`. Async reset forces state = RST (0) and retired = 0.
- Outputs are combinational from the state (plus `mem_ready` where noted). Any output not listed for a state is 0.
- In RST all outputs are 0.
- States, asserted outputs, and next state:
  - RST(0): none. Next: FETCH.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite = PCWrite = mem_ready. Next: DECODE if mem_ready, else stay in FETCH.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next by opcode:
    - 100011 or 101011 (lw/sw): MEMADR.
    - 000000 (R-type): EXEC.
    - 000100 (beq): BRANCH.
    - 001000 (addi): ADDIEX.
    - 000010 (j): JUMP.
    - anything else: illegal_op=1, next FETCH. No retire.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD if opcode = lw, else MEMWR.
  - MEMRD(4): MemRead=1, IorD=1. Next: MEMWB if mem_ready, else stay.
  - MEMWB(5): RegWrite=1, MemToReg=1, RegDst=0, instr_done=1. Next: FETCH.
  - MEMWR(6): MemWrite=1, IorD=1 (held until ready). instr_done = mem_ready. Next: FETCH if mem_ready, else stay.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB(8): RegDst=1, RegWrite=1, instr_done=1. Next: FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next: FETCH.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB(11): RegWrite=1, RegDst=0, MemToReg=0, instr_done=1. Next: FETCH.
  - JUMP(12): PCWrite=1, PCSource=10, instr_done=1. Next: FETCH.
  - Encodings 13-15: all outputs 0, next FETCH. They are unreachable but must recover.
- Latency with zero wait states (mem_ready held high), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. The strobes stay asserted and stable while waiting.
- `mem_ready` is ignored in every other state.
- `retired` increments by 1 on each clock edge where instr_done=1. It wraps from all-ones to 0 with no flag.
- `opcode` is sampled combinationally in DECODE and MEMADR only.
- Reset asserted mid-instruction (including mid-wait) aborts immediately: state = RST, no further strobes, retired = 0.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=000000 → states 0,1,2,7,8,1; RegWrite and RegDst high only in state 8; retired=1.
- opcode=100011, mem_ready low for 2 cycles in MEMRD → sequence 1,2,3,4,4,4,5; MemRead and IorD held through the wait; MemToReg=1 in state 5; 6 cycles after FETCH accept.
- opcode=101011 with mem_ready=1 → states 1,2,3,6; MemWrite=1 for exactly 1 cycle; instr_done pulses in state 6; RegWrite never asserted.
- beq then j back-to-back → BRANCH asserts PCWriteCond=1, PCSource=01, ALUOp=01; JUMP asserts PCWrite=1, PCSource=10; retired increments by 2.
- opcode=111111 → illegal_op pulses for 1 cycle in DECODE, returns to FETCH, retired unchanged, no write strobe.
- Assert rst_n=0 during a MEMRD wait → state=0 and all outputs 0 asynchronously, before the next edge.
